// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared constants and types for the push-button front end
package btn_pkg;

  localparam int NUM_BTN = 5;

  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_L = 2;
  localparam int BTN_R = 3;
  localparam int BTN_D = 4;

  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_REPEAT_DELAY    = 50_000_000;
  localparam int DEF_REPEAT_PERIOD   = 10_000_000;
  localparam logic [NUM_BTN-1:0] DEF_REPEAT_MASK = 5'b10010;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// rtl/btn_conditioner_if.sv - raw button inputs and conditioned level/pulse outputs
interface btn_conditioner_if;
  import btn_pkg::*;

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release
  );

endinterface

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - one button: synchroniser, stable-count debounce, edge pulses, optional auto-repeat
module btn_debounce
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter bit REPEAT_EN       = 1'b0
) (
  input  logic clk100mhz,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam int RPT_MAX  = max2(REPEAT_DELAY, REPEAT_PERIOD);
  localparam int RPT_W    = $clog2(RPT_MAX + 1);
  localparam int DLY_LOAD = (REPEAT_DELAY > 1) ? REPEAT_DELAY - 1 : 0;
  localparam int PER_LOAD = (REPEAT_PERIOD > 1) ? REPEAT_PERIOD - 1 : 0;

  logic [1:0]       sync;
  logic             s;
  logic [CNT_W-1:0] cnt;
  logic             cnt_done;
  logic             flip;
  logic             rise;
  logic             fall;

  rpt_state_t       state, state_nxt;
  logic [RPT_W-1:0] rcnt, rcnt_nxt;
  logic             rpt_pulse;

  assign s        = sync[1];
  assign cnt_done = (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign flip     = (s != level) && cnt_done;
  assign rise     = flip && s;
  assign fall     = flip && !s;

  always_ff @(posedge clk100mhz or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (s == level || cnt_done) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if (flip) begin
        level <= s;
      end
    end
  end

  // Down-counter reloads on every press/repeat pulse, so it never needs to wrap.
  always_comb begin
    state_nxt = state;
    rcnt_nxt  = rcnt;
    rpt_pulse = 1'b0;
    case (state)
      RPT_IDLE: begin
        if (rise) begin
          state_nxt = RPT_DELAY;
          rcnt_nxt  = RPT_W'(DLY_LOAD);
        end
      end
      RPT_DELAY, RPT_REPEAT: begin
        if (fall) begin
          state_nxt = RPT_IDLE;
          rcnt_nxt  = '0;
        end else if (rcnt == '0) begin
          rpt_pulse = 1'b1;
          state_nxt = RPT_REPEAT;
          rcnt_nxt  = RPT_W'(PER_LOAD);
        end else begin
          rcnt_nxt  = rcnt - RPT_W'(1);
        end
      end
      default: begin
        state_nxt = RPT_IDLE;
        rcnt_nxt  = '0;
      end
    endcase
    if (!REPEAT_EN) begin
      state_nxt = RPT_IDLE;
      rcnt_nxt  = '0;
      rpt_pulse = 1'b0;
    end
  end

  always_ff @(posedge clk100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RPT_IDLE;
      rcnt          <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_nxt;
      rcnt          <= rcnt_nxt;
      press_pulse   <= rise || rpt_pulse;
      release_pulse <= fall;
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - five independent button conditioners feeding the LED controller
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK = DEF_REPEAT_MASK
) (
  input  logic clk100mhz,
  input  logic rst_n,
  btn_conditioner_if.slave bus
);

  logic [NUM_BTN-1:0] level_v;
  logic [NUM_BTN-1:0] press_v;
  logic [NUM_BTN-1:0] release_v;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .REPEAT_EN       (REPEAT_MASK[i])
    ) u_btn (
      .clk100mhz     (clk100mhz),
      .rst_n         (rst_n),
      .raw           (bus.btn_raw[i]),
      .level         (level_v[i]),
      .press_pulse   (press_v[i]),
      .release_pulse (release_v[i])
    );
  end

  assign bus.btn_level   = level_v;
  assign bus.btn_press   = press_v;
  assign bus.btn_release = release_v;

endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - directed table-driven bench for btn_conditioner
module tb_btn_conditioner;
  import btn_pkg::*;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic clk100mhz = 1'b0;
  logic rst_n     = 1'b1;

  btn_conditioner_if bus ();

  btn_conditioner #(
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP),
    .REPEAT_MASK     (5'b10010)
  ) dut (
    .clk100mhz (clk100mhz),
    .rst_n     (rst_n),
    .bus       (bus.slave)
  );

  always #5 clk100mhz = ~clk100mhz;

  int cyc = 0;
  always @(posedge clk100mhz) cyc++;

  int press_cnt [NUM_BTN] = '{default: 0};
  int rel_cnt   [NUM_BTN] = '{default: 0};
  int last_press[NUM_BTN] = '{default: -1};
  int last_rel  [NUM_BTN] = '{default: -1};
  int last_any_press = -1;
  int last_any_rel   = -1;
  int both_cnt       = 0;
  int q_u[$];

  always @(posedge clk100mhz) begin
    #2;
    for (int b = 0; b < NUM_BTN; b++) begin
      if (bus.btn_press[b]) begin
        press_cnt[b]++;
        last_press[b] = cyc;
        last_any_press = cyc;
        if (b == BTN_U) q_u.push_back(cyc);
      end
      if (bus.btn_release[b]) begin
        rel_cnt[b]++;
        last_rel[b] = cyc;
        last_any_rel = cyc;
      end
      if (bus.btn_press[b] && bus.btn_release[b]) both_cnt++;
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk100mhz);
    #3;
  endtask

  function automatic int sum_press();
    int t = 0;
    for (int b = 0; b < NUM_BTN; b++) t += press_cnt[b];
    return t;
  endfunction

  function automatic int sum_rel();
    int t = 0;
    for (int b = 0; b < NUM_BTN; b++) t += rel_cnt[b];
    return t;
  endfunction

  typedef struct {
    logic [4:0] raw;
    int         hold;
    logic [4:0] lvl;
    int         np;
    int         nr;
    int         pofs;
    int         rofs;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int seg, p0, r0, c, r, p, n4, rel4;

    tbl.push_back('{5'b00000, 10, 5'b00000, 0, 0, -1, -1});
    tbl.push_back('{5'b00001, 50, 5'b00001, 1, 0,  6, -1});
    tbl.push_back('{5'b00000, 10, 5'b00000, 0, 1, -1,  6});
    tbl.push_back('{5'b00100,  3, 5'b00000, 0, 0, -1, -1});
    tbl.push_back('{5'b00000,  1, 5'b00000, 0, 0, -1, -1});
    tbl.push_back('{5'b00100,  3, 5'b00000, 0, 0, -1, -1});
    tbl.push_back('{5'b00000, 10, 5'b00000, 0, 0, -1, -1});
    tbl.push_back('{5'b01100, 30, 5'b01100, 2, 0,  6, -1});
    tbl.push_back('{5'b00000, 10, 5'b00000, 0, 2, -1,  6});
    tbl.push_back('{5'b00010, 50, 5'b00010, 5, 0, 50, -1});
    tbl.push_back('{5'b00000, 12, 5'b00000, 0, 1, -1,  6});

    bus.btn_raw = '0;
    #1 rst_n = 1'b0;
    #1;
    check("reset_level",   int'(bus.btn_level),   0);
    check("reset_press",   int'(bus.btn_press),   0);
    check("reset_release", int'(bus.btn_release), 0);
    tick(3);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      seg = cyc;
      p0  = sum_press();
      r0  = sum_rel();
      bus.btn_raw = tbl[i].raw;
      tick(tbl[i].hold);
      check($sformatf("vec%0d_level", i), int'(bus.btn_level), int'(tbl[i].lvl));
      check($sformatf("vec%0d_npress", i), sum_press() - p0, tbl[i].np);
      check($sformatf("vec%0d_nrelease", i), sum_rel() - r0, tbl[i].nr);
      if (tbl[i].pofs >= 0) check($sformatf("vec%0d_press_ofs", i), last_any_press - seg, tbl[i].pofs);
      if (tbl[i].rofs >= 0) check($sformatf("vec%0d_release_ofs", i), last_any_rel - seg, tbl[i].rofs);
    end

    // btnu repeat cadence: press, +20, then every +8
    check("btnu_repeat_count", q_u.size(), 5);
    for (int k = 1; k < q_u.size(); k++) begin
      check($sformatf("btnu_gap%0d", k), q_u[k] - q_u[k-1], (k == 1) ? RD : RP);
    end

    // Reset while btnd is held and debounced
    c = cyc;
    bus.btn_raw = 5'b10000;
    tick(10);
    check("btnd_level_before_rst", int'(bus.btn_level), 5'b10000);
    check("btnd_press_ofs", last_press[BTN_D] - c, 6);
    rel4 = rel_cnt[BTN_D];
    rst_n = 1'b0;
    #1;
    check("midhold_rst_level",   int'(bus.btn_level),   0);
    check("midhold_rst_press",   int'(bus.btn_press),   0);
    check("midhold_rst_release", int'(bus.btn_release), 0);
    tick(3);
    rst_n = 1'b1;
    r  = cyc;
    n4 = press_cnt[BTN_D];
    tick(8);
    check("btnd_repress_ofs", last_press[BTN_D] - r, 6);
    check("btnd_repress_count", press_cnt[BTN_D] - n4, 1);
    check("btnd_no_release_on_rst", rel_cnt[BTN_D] - rel4, 0);

    // Release debounces on the cycle the first repeat is due: release wins
    p = r + 6;
    tick(p + 14 - cyc);
    bus.btn_raw = 5'b00000;
    tick(10);
    check("collide_release_ofs", last_rel[BTN_D] - p, RD);
    check("collide_no_repeat", last_press[BTN_D] - p, 0);
    check("collide_level", int'(bus.btn_level), 0);
    check("never_press_and_release", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
